// File: rtl/button_conditioner_pkg.sv
// Shared types and defaults for the push-button conditioner.
package button_conditioner_pkg;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
  localparam int unsigned DEF_SYNC_STAGES     = 2;

  typedef enum logic [1:0] {
    S_LOW    = 2'd0,
    S_WAIT_H = 2'd1,
    S_HIGH   = 2'd2,
    S_WAIT_L = 2'd3
  } state_t;

endpackage

// File: rtl/button_conditioner_if.sv
// Button input and conditioned outputs; master drives BTN, slave is the conditioner.
interface button_conditioner_if;

  logic BTN;
  logic D;
  logic RISE;
  logic FALL;
  logic BUSY;

  modport master (output BTN, input D, RISE, FALL, BUSY);
  modport slave  (input BTN, output D, RISE, FALL, BUSY);

endinterface

// File: rtl/button_conditioner_sync_chain.sv
// Multi-flop synchroniser bringing the asynchronous button level into the CLK domain.
module sync_chain
  import button_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic CLK,
  input  logic RST,
  input  logic D_IN,
  output logic D_OUT
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) stages <= '0;
    else     stages <= {stages[SYNC_STAGES-2:0], D_IN};
  end

  assign D_OUT = stages[SYNC_STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Synchronises and debounces a raw button level; emits level, edge pulses and busy flag.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic                 CLK,
  input  logic                 RST,
  button_conditioner_if.slave  bus
);

  localparam int unsigned    CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             d_nxt, rise_nxt, fall_nxt, busy_nxt;
  logic             d_q, rise_q, fall_q, busy_q;

  sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CLK   (CLK),
    .RST   (RST),
    .D_IN  (bus.BTN),
    .D_OUT (s)
  );

  // State, qualification counter and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= S_LOW;
      cnt    <= '0;
      d_q    <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      d_q    <= d_nxt;
      rise_q <= rise_nxt;
      fall_q <= fall_nxt;
      busy_q <= busy_nxt;
    end
  end

  // Counter is cleared on every WAIT entry and checked before incrementing, so it never wraps.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_LOW: begin
        if (s) begin
          state_nxt = S_WAIT_H;
          cnt_nxt   = '0;
        end
      end
      S_WAIT_H: begin
        if (!s)                  state_nxt = S_LOW;
        else if (cnt == CNT_MAX) state_nxt = S_HIGH;
        else                     cnt_nxt   = cnt + CNT_W'(1);
      end
      S_HIGH: begin
        if (!s) begin
          state_nxt = S_WAIT_L;
          cnt_nxt   = '0;
        end
      end
      S_WAIT_L: begin
        if (s)                   state_nxt = S_HIGH;
        else if (cnt == CNT_MAX) state_nxt = S_LOW;
        else                     cnt_nxt   = cnt + CNT_W'(1);
      end
      default: state_nxt = S_LOW;
    endcase
  end

  // Output values decoded from the upcoming state so they register alongside it.
  always_comb begin
    d_nxt    = (state_nxt == S_HIGH)   || (state_nxt == S_WAIT_L);
    busy_nxt = (state_nxt == S_WAIT_H) || (state_nxt == S_WAIT_L);
    rise_nxt = (state == S_WAIT_H) && (state_nxt == S_HIGH);
    fall_nxt = (state == S_WAIT_L) && (state_nxt == S_LOW);
  end

  assign bus.D    = d_q;
  assign bus.RISE = rise_q;
  assign bus.FALL = fall_q;
  assign bus.BUSY = busy_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboarded bench: run-length debounce model predicts {D,RISE,FALL,BUSY} each cycle.
module tb_button_conditioner;
  import button_conditioner_pkg::*;

  localparam int unsigned DB  = DEF_DEBOUNCE_CYCLES;
  localparam int unsigned SS  = DEF_SYNC_STAGES;
  localparam int          LAT = int'(SS + DB + 1);

  logic CLK;
  logic RST;

  button_conditioner_if bif();

  button_conditioner #(.DEBOUNCE_CYCLES(DB), .SYNC_STAGES(SS)) u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bif.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;

  logic [3:0] exp_q[$];
  bit         m_hist[$];
  bit         m_d;
  int         m_run;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] outs();
    return {bif.D, bif.RISE, bif.FALL, bif.BUSY};
  endfunction

  task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {D,RISE,FALL,BUSY}=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    repeat (SS) m_hist.push_back(1'b0);
    m_d   = 1'b0;
    m_run = 0;
  endtask

  // Reference: the level flips once the synchronised input has differed from it on DB+1 consecutive edges.
  always @(posedge CLK) begin
    bit s, rise, fall;
    if (RST) begin
      model_reset();
      exp_q.push_back(4'b0000);
    end else begin
      s = m_hist.pop_front();
      m_hist.push_back(bif.BTN);
      rise = 1'b0;
      fall = 1'b0;
      if (s != m_d) m_run++;
      else          m_run = 0;
      if (m_run == int'(DB) + 1) begin
        m_d   = ~m_d;
        rise  = m_d;
        fall  = ~m_d;
        m_run = 0;
      end
      exp_q.push_back({m_d, rise, fall, m_run > 0});
    end
  end

  always @(negedge CLK) begin
    logic [3:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = outs();
      chk("scoreboard", a, e);
      chk_int("rise_fall_exclusive", int'(a[2] & a[1]), 0);
      if (a[2] == 1'b1) rise_cnt++;
      if (a[1] == 1'b1) fall_cnt++;
    end
  end

  // Hold BTN at v for exactly n sampling edges.
  task automatic drive(bit v, int n);
    @(negedge CLK);
    #1;
    bif.BTN = v;
    repeat (n - 1) @(negedge CLK);
  endtask

  // Apply v (optionally releasing reset) and report the edge at which D first equals v.
  task automatic measure(string name, bit v, bit rel);
    int found;
    found = 0;
    @(negedge CLK);
    #1;
    if (rel) RST = 1'b0;
    bif.BTN = v;
    for (int e = 1; e <= LAT + 6; e++) begin
      @(posedge CLK);
      #1;
      if (found == 0 && bif.D === v) found = e;
    end
    chk_int(name, found, LAT);
  endtask

  initial begin
    int r0, f0;
    RST     = 1'b1;
    bif.BTN = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    chk("reset_outputs", outs(), 4'b0000);
    #1 RST = 1'b0;

    drive(1'b0, 100);

    r0 = rise_cnt;
    measure("rise_latency", 1'b1, 1'b0);
    drive(1'b1, 5);
    chk_int("rise_count", rise_cnt - r0, 1);

    f0 = fall_cnt;
    measure("fall_latency", 1'b0, 1'b0);
    drive(1'b0, 5);
    chk_int("fall_count", fall_cnt - f0, 1);

    r0 = rise_cnt;
    drive(1'b1, 10);
    drive(1'b0, 30);
    chk_int("short_pulse_no_rise", rise_cnt - r0, 0);

    r0 = rise_cnt;
    repeat (5) begin
      drive(1'b1, 3);
      drive(1'b0, 3);
    end
    measure("bounce_rise_latency", 1'b1, 1'b0);
    drive(1'b1, 5);
    chk_int("bounce_single_rise", rise_cnt - r0, 1);

    drive(1'b0, 40);

    // Reset between edges while qualifying a rise with eight counts accumulated.
    @(negedge CLK);
    #1 bif.BTN = 1'b1;
    repeat (11) @(posedge CLK);
    @(negedge CLK);
    #1 RST = 1'b1;
    #1 chk("async_reset_mid_wait", outs(), 4'b0000);
    r0 = rise_cnt;
    measure("post_reset_rise_latency", 1'b1, 1'b1);
    drive(1'b1, 5);
    chk_int("post_reset_rise_count", rise_cnt - r0, 1);

    repeat (80) drive(1'($urandom_range(0, 1)), int'($urandom_range(1, 2 * DB + 4)));
    drive(1'b0, 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
